indirect_mem_seq: RTL and testbench
===================================

INDIRECT_MEM_SEQ -- requirements
Module: indirect_mem_seq

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 opcode  input  4  lc3b_opcode of the MEM-stage instruction.
REQ-005 valid  input  1  MEM-stage instruction is valid.
REQ-006 addr_in  input  16  MEM-stage effective address (BaseR + SEXT(offset6)<<1).
REQ-007 store_data  input  16  SR value for STI.
REQ-008 dmem_resp  input  1  data memory completed the current request.
REQ-009 dmem_rdata  input  16  data memory read word.
REQ-010 dmem_read  output  1  read request.
REQ-011 dmem_write  output  1  write request.
REQ-012 dmem_address  output  16  request address, bit 0 always 0.
REQ-013 dmem_wdata  output  16  write data.
REQ-014 dmem_byte_enable  output  2  byte enables.
REQ-015 stall  output  1  freeze all pipeline stages.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 result  output  16  LDI loaded value; valid when done=1 for LDI.

Function
REQ-018 SHALL handle only op_ldi (4'b1010) and op_sti (4'b1011); all other opcodes SHALL leave the block in IDLE with every output 0.
REQ-019 States SHALL be IDLE, PTR, DATA_RD, DATA_WR, DONE.
REQ-020 Trigger = IDLE & valid & opcode in {ldi, sti}.
REQ-021 IDLE: on trigger, latch {addr_in[15:1],0} as addr_q, store_data as wdata_q, opcode as op_q; go to PTR.
REQ-022 stall SHALL be 1 combinationally in the IDLE trigger cycle and in PTR, DATA_RD and DATA_WR; stall SHALL be 0 in DONE and in non-trigger IDLE.
REQ-023 PTR: dmem_read=1, dmem_address=addr_q; hold until dmem_resp.
REQ-024 PTR with dmem_resp: latch ptr_q={dmem_rdata[15:1],0}; go to DATA_RD if op_q=ldi, else DATA_WR.
REQ-025 DATA_RD: dmem_read=1, dmem_address=ptr_q; on dmem_resp latch result=dmem_rdata, go to DONE.
REQ-026 DATA_WR: dmem_write=1, dmem_address=ptr_q, dmem_wdata=wdata_q, dmem_byte_enable=2'b11; on dmem_resp go to DONE.
REQ-027 dmem_byte_enable SHALL be 2'b00 in every state other than DATA_WR; dmem_read and dmem_write SHALL never both be 1.
REQ-028 DONE: done=1 for exactly one cycle, stall=0 so the pipeline advances; unconditionally go to IDLE; inputs ignored.
REQ-029 result SHALL hold its value until the next LDI completes or reset; STI SHALL NOT modify result.
REQ-030 Request signals SHALL stay constant while waiting for dmem_resp; waits of any length (including 0 extra cycles, resp in the first request cycle) SHALL be supported.
REQ-031 dmem_resp in IDLE or DONE SHALL be ignored.
REQ-032 Back-to-back indirect instructions: second instruction triggers from IDLE in the cycle after DONE.
REQ-033 Minimum latency with single-cycle memory: trigger cycle, PTR, DATA_x, DONE = 4 cycles with done in the 4th.

Reset
REQ-034 On reset, state SHALL become IDLE and addr_q, ptr_q, wdata_q, result SHALL be 0.
REQ-035 During and after reset, dmem_read, dmem_write, done and stall SHALL be 0, dmem_byte_enable 2'b00, dmem_address 0, dmem_wdata 0.
REQ-036 Reset asserted mid-operation (any state) SHALL abort the sequence at that edge; the outstanding memory request SHALL be dropped and no done pulse produced.

Verification
REQ-037 LDI, addr_in=x3001, mem[x3000]=x4005, mem[x4004]=xBEEF, 1-cycle resp -> reads x3000 then x4004, done in cycle 4, result=xBEEF.
REQ-038 STI, addr_in=x2000, store_data=x1234, mem[x2000]=x5000 -> read x2000, write x5000 data x1234 be 2'b11, result unchanged.
REQ-039 LDI with dmem_resp delayed 5 cycles per access -> stall held 1 through both waits, address/read stable, done single pulse.
REQ-040 LDI immediately followed by STI -> two separate sequences, done pulses 1 cycle apart from IDLE re-trigger, no overlapping requests.
REQ-041 Reset asserted while in DATA_RD -> next cycle IDLE, all outputs 0, no done, result=0.
REQ-042 op_add/op_ldr with valid=1 and random dmem_resp -> stall=0, no memory requests, state stays IDLE.

Source files
------------

// File: rtl/indirect_mem_seq.sv
// Indirect memory sequencer for the LC-3b MEM stage.
// Executes LDI (load through a pointer) and STI (store through a pointer)
// as two back-to-back data memory accesses while freezing the pipeline.
//
// Memory handshake: a request (dmem_read or dmem_write, with dmem_address,
// dmem_wdata and dmem_byte_enable) is presented and held constant until the
// memory answers with dmem_resp. The request completes on the rising edge
// where dmem_resp is 1, and dmem_rdata is sampled on that edge. dmem_resp is
// ignored whenever no request is outstanding.
module indirect_mem_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  opcode,
    input  logic        valid,
    input  logic [15:0] addr_in,
    input  logic [15:0] store_data,
    input  logic        dmem_resp,
    input  logic [15:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    output logic        stall,
    output logic        done,
    output logic [15:0] result,
    output logic [2:0]  dbg_state
);

    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PTR     = 3'd1,
        DATA_RD = 3'd2,
        DATA_WR = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        trigger;
    logic [15:0] addr_q;
    logic [15:0] ptr_q;
    logic [15:0] wdata_q;
    logic [3:0]  op_q;

    // Word addresses are always even; the incoming byte-select bit is dropped.
    logic unused_addr_bit;
    assign unused_addr_bit = addr_in[0];

    assign dbg_state = state;

    // A new indirect instruction is accepted only from IDLE.
    always_comb begin
        trigger = 1'b0;
        if (state == IDLE && valid && (opcode == OP_LDI || opcode == OP_STI)) begin
            trigger = 1'b1;
        end
    end

    // Next-state selection; each memory state waits for dmem_resp.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (trigger) state_next = PTR;
            end
            PTR: begin
                if (dmem_resp) state_next = (op_q == OP_LDI) ? DATA_RD : DATA_WR;
            end
            DATA_RD: begin
                if (dmem_resp) state_next = DONE;
            end
            DATA_WR: begin
                if (dmem_resp) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory request and pipeline control outputs, forced quiet while reset is high.
    always_comb begin
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = 16'h0000;
        dmem_wdata       = 16'h0000;
        dmem_byte_enable = 2'b00;
        stall            = 1'b0;
        done             = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    stall = trigger;
                end
                PTR: begin
                    dmem_read    = 1'b1;
                    dmem_address = addr_q;
                    stall        = 1'b1;
                end
                DATA_RD: begin
                    dmem_read    = 1'b1;
                    dmem_address = ptr_q;
                    stall        = 1'b1;
                end
                DATA_WR: begin
                    dmem_write       = 1'b1;
                    dmem_address     = ptr_q;
                    dmem_wdata       = wdata_q;
                    dmem_byte_enable = 2'b11;
                    stall            = 1'b1;
                end
                DONE: begin
                    done = 1'b1;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

    // State register and operand/pointer/result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= 16'h0000;
            ptr_q   <= 16'h0000;
            wdata_q <= 16'h0000;
            op_q    <= 4'h0;
            result  <= 16'h0000;
        end else begin
            state <= state_next;
            if (trigger) begin
                addr_q  <= {addr_in[15:1], 1'b0};
                wdata_q <= store_data;
                op_q    <= opcode;
            end
            if (state == PTR && dmem_resp) begin
                ptr_q <= {dmem_rdata[15:1], 1'b0};
            end
            if (state == DATA_RD && dmem_resp) begin
                result <= dmem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_indirect_mem_seq.sv
// Bench for indirect_mem_seq: directed LDI/STI sequences against a memory
// model with programmable response delay, scoreboard of expected accesses.
module tb_indirect_mem_seq;

  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LDR = 4'b0110;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic        valid;
  logic [15:0] addr_in;
  logic [15:0] store_data;
  logic        dmem_resp = 1'b0;
  logic [15:0] dmem_rdata = 16'h0000;
  logic        dmem_read;
  logic        dmem_write;
  logic [15:0] dmem_address;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic        stall;
  logic        done;
  logic [15:0] result;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  indirect_mem_seq dut (
    .clk(clk),
    .reset(reset),
    .opcode(opcode),
    .valid(valid),
    .addr_in(addr_in),
    .store_data(store_data),
    .dmem_resp(dmem_resp),
    .dmem_rdata(dmem_rdata),
    .dmem_read(dmem_read),
    .dmem_write(dmem_write),
    .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable),
    .stall(stall),
    .done(done),
    .result(result),
    .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_total = 0;
  int n_pass = 0;
  int cyc_cnt = 0;
  int done_cyc = 0;
  int resp_delay = 0;
  int wait_cnt = 0;
  logic [15:0] mem [logic [15:0]];
  // {kind, address, data}: kind 1 = read, 2 = write, 3 = done with result
  logic [33:0] exp_q[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic sb_pop(input string name, input logic [33:0] act);
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: unexpected event %h with nothing expected", name, act);
    end else begin
      chk(name, act, exp_q.pop_front());
    end
  endtask

  // ---------------- memory model ----------------
  // Answers an outstanding request after resp_delay wait cycles; drives
  // random dmem_resp when nothing is requested.
  always @(negedge clk) begin
    if (dmem_read || dmem_write) begin
      if (wait_cnt >= resp_delay) begin
        dmem_resp = 1'b1;
        wait_cnt = 0;
        if (dmem_read) begin
          dmem_rdata = mem.exists(dmem_address) ? mem[dmem_address] : 16'h0000;
        end else begin
          mem[dmem_address] = dmem_wdata;
          dmem_rdata = 16'($urandom);
        end
      end else begin
        dmem_resp = 1'b0;
        wait_cnt++;
        dmem_rdata = 16'($urandom);
      end
    end else begin
      dmem_resp = 1'($urandom_range(0, 1));
      dmem_rdata = 16'($urandom);
      wait_cnt = 0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        p_act = 1'b0;
  logic        p_resp = 1'b0;
  logic        p_rst = 1'b1;
  logic        p_done = 1'b0;
  logic [33:0] p_req = '0;

  always @(negedge clk) begin
    logic [33:0] cur_req;
    logic        act;
    #2;
    act = dmem_read | dmem_write;
    cur_req = {dmem_read, dmem_write, dmem_address, dmem_wdata};
    chk("rw_exclusive", 34'(dmem_read & dmem_write), 34'd0);
    chk("byte_enable", 34'(dmem_byte_enable), dmem_write ? 34'd3 : 34'd0);
    chk("addr_bit0", 34'(dmem_address[0]), 34'd0);
    chk("req_stall", 34'(act & ~stall), 34'd0);
    if (p_act && !p_resp && !reset && !p_rst) chk("req_hold", cur_req, p_req);
    if (act && dmem_resp && !reset) begin
      sb_pop("mem_access", {dmem_read ? 2'd1 : 2'd2, dmem_address, dmem_write ? dmem_wdata : 16'h0000});
    end
    if (done) begin
      chk("done_stall", 34'(stall), 34'd0);
      chk("done_single", 34'(p_done), 34'd0);
      sb_pop("done_result", {2'd3, 16'h0000, result});
    end
    p_act = act;
    p_resp = dmem_resp;
    p_rst = reset;
    p_done = done;
    p_req = cur_req;
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] sd,
                       input logic [15:0] e_ptr_addr, input logic [15:0] e_data_addr,
                       input logic [15:0] e_res, input int dly, input int e_lat);
    int lat;
    bit got;
    @(posedge clk);
    #1;
    resp_delay = dly;
    exp_q.push_back({2'd1, e_ptr_addr, 16'h0000});
    if (op == OP_LDI) exp_q.push_back({2'd1, e_data_addr, 16'h0000});
    else exp_q.push_back({2'd2, e_data_addr, sd});
    exp_q.push_back({2'd3, 16'h0000, e_res});
    valid = 1'b1;
    opcode = op;
    addr_in = a;
    store_data = sd;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clk);
      #3;
      lat++;
      if (lat == 1) chk("trigger_stall", 34'(stall), 34'd1);
      if (done) got = 1'b1;
    end
    chk("latency", 34'(lat), 34'(e_lat));
    done_cyc = cyc_cnt;
  endtask

  task automatic idle_inputs();
    @(posedge clk);
    #1;
    valid = 1'b0;
    opcode = 4'h0;
    addr_in = 16'h0000;
    store_data = 16'h0000;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d1;
    int n;
    reset = 1'b1;
    valid = 1'b1;
    opcode = OP_LDI;
    addr_in = 16'h3001;
    store_data = 16'hFFFF;
    mem[16'h3000] = 16'h4005;
    mem[16'h4004] = 16'hBEEF;
    mem[16'h2000] = 16'h5000;
    mem[16'h6002] = 16'h7001;
    mem[16'h7000] = 16'hCAFE;
    mem[16'h1000] = 16'h1100;
    mem[16'h1100] = 16'h0BAD;
    mem[16'h1002] = 16'h1203;
    mem[16'h0ABC] = 16'h8001;

    // Reset: outputs quiet even with a valid LDI presented.
    repeat (2) @(negedge clk);
    #3;
    chk("rst_ctrl", 34'({dmem_read, dmem_write, done, stall, dmem_byte_enable}), 34'd0);
    chk("rst_addr", 34'(dmem_address), 34'd0);
    chk("rst_wdata", 34'(dmem_wdata), 34'd0);
    chk("rst_result", 34'(result), 34'd0);
    chk("rst_state", 34'(dbg_state), 34'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    #3;
    chk("post_rst_idle", 34'({dbg_state, dmem_read, dmem_write, done, stall}), 34'd0);

    // LDI x3001 -> read x3000 (x4005), read x4004 (xBEEF), done in cycle 4.
    issue(OP_LDI, 16'h3001, 16'h0000, 16'h3000, 16'h4004, 16'hBEEF, 0, 4);
    idle_inputs();

    // STI x2000 data x1234 -> read x2000 (x5000), write x5000; result unchanged.
    issue(OP_STI, 16'h2000, 16'h1234, 16'h2000, 16'h5000, 16'hBEEF, 0, 4);
    idle_inputs();
    chk("sti_mem", 34'(mem[16'h5000]), 34'h1234);

    // LDI with 5 wait cycles per access: 1 + 6 + 6 + 1 = 14 cycles.
    issue(OP_LDI, 16'h6003, 16'h0000, 16'h6002, 16'h7000, 16'hCAFE, 5, 14);
    idle_inputs();

    // LDI followed immediately by STI; pointer x1203 is word-aligned to x1202.
    issue(OP_LDI, 16'h1000, 16'h0000, 16'h1000, 16'h1100, 16'h0BAD, 0, 4);
    d1 = done_cyc;
    issue(OP_STI, 16'h1002, 16'hA5A5, 16'h1002, 16'h1202, 16'h0BAD, 0, 4);
    chk("b2b_done_gap", 34'(done_cyc - d1), 34'd4);
    idle_inputs();
    chk("b2b_mem", 34'(mem[16'h1202]), 34'hA5A5);

    // STI with 2 wait cycles per access: 1 + 3 + 3 + 1 = 8 cycles.
    issue(OP_STI, 16'h0ABC, 16'h5A5A, 16'h0ABC, 16'h8000, 16'h0BAD, 2, 8);
    idle_inputs();
    chk("sti2_mem", 34'(mem[16'h8000]), 34'h5A5A);

    // Reset while waiting in DATA_RD: sequence aborted, result cleared.
    @(posedge clk);
    #1;
    resp_delay = 3;
    exp_q.push_back({2'd1, 16'h3000, 16'h0000});
    valid = 1'b1;
    opcode = OP_LDI;
    addr_in = 16'h3001;
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (dbg_state != 3'd2 && n < 50);
    chk("reach_data_rd", 34'(dbg_state), 34'd2);
    reset = 1'b1;
    valid = 1'b0;
    opcode = 4'h0;
    addr_in = 16'h0000;
    @(negedge clk);
    #3;
    chk("abort_state", 34'(dbg_state), 34'd0);
    chk("abort_ctrl", 34'({dmem_read, dmem_write, done, stall, dmem_byte_enable}), 34'd0);
    chk("abort_addr", 34'(dmem_address), 34'd0);
    chk("abort_result", 34'(result), 34'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #3;
    chk("abort_no_done", 34'({dbg_state, done}), 34'd0);
    chk("abort_q_empty", 34'(exp_q.size()), 34'd0);

    // Non-indirect opcodes with random dmem_resp: no requests, no stall.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      valid = 1'b1;
      opcode = (i % 2 == 0) ? OP_ADD : OP_LDR;
      addr_in = 16'($urandom);
      @(negedge clk);
      #3;
      chk("other_op_quiet", 34'({dbg_state, dmem_read, dmem_write, done, stall}), 34'd0);
    end
    idle_inputs();

    // Recovery after reset: LDI with 1 wait cycle per access: 1 + 2 + 2 + 1 = 6.
    issue(OP_LDI, 16'h3001, 16'h0000, 16'h3000, 16'h4004, 16'hBEEF, 1, 6);
    idle_inputs();

    repeat (3) @(negedge clk);
    #3;
    chk("sb_empty", 34'(exp_q.size()), 34'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
